// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs and processor status,
// plus the status-priority helper used by write-back.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'd4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    // Address faults outrank illegal instructions, which outrank halt.
    function automatic stat_e next_stat(input logic imem_error, input logic dmem_error,
                                        input logic instr_valid, input logic [3:0] icode);
        stat_e s;
        if (imem_error || dmem_error) begin
            s = SADR;
        end else if (!instr_valid) begin
            s = SINS;
        end else if (icode == IHALT) begin
            s = SHLT;
        end else begin
            s = SAOK;
        end
        return s;
    endfunction

endpackage

// File: rtl/y86_wb_regfile_if.sv
// Bundle of the per-instruction inputs and decode/read/status outputs of the
// write-back stage; the datapath drives it as master, write-back is the slave.
interface y86_wb_regfile_if #(
    parameter int CNTW = 32
);
    logic            commit;
    logic [3:0]      icode;
    logic            cnd;
    logic [3:0]      rA;
    logic [3:0]      rB;
    logic [63:0]     valE;
    logic [63:0]     valM;
    logic            imem_error;
    logic            dmem_error;
    logic            instr_valid;
    logic [3:0]      srcA;
    logic [3:0]      srcB;
    logic [3:0]      dstE;
    logic [3:0]      dstM;
    logic [63:0]     valA;
    logic [63:0]     valB;
    logic [2:0]      stat;
    logic            halted;
    logic [CNTW-1:0] retired;

    modport master (
        output commit, icode, cnd, rA, rB, valE, valM, imem_error, dmem_error, instr_valid,
        input  srcA, srcB, dstE, dstM, valA, valB, stat, halted, retired
    );

    modport slave (
        input  commit, icode, cnd, rA, rB, valE, valM, imem_error, dmem_error, instr_valid,
        output srcA, srcB, dstE, dstM, valA, valB, stat, halted, retired
    );

endinterface

// File: rtl/y86_regfile.sv
// Architectural register file: NREG x 64 storage, two combinational read ports,
// two write ports where port M wins on a shared destination. IDs >= NREG are "none".
module y86_regfile #(
    parameter int NREG = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs_r [NREG];

    // Read ports return pre-write contents; no bypass from the write ports.
    always_comb begin
        val_a = 64'd0;
        val_b = 64'd0;
        if (int'(src_a) < NREG) begin
            val_a = regs_r[src_a];
        end else begin
            val_a = 64'd0;
        end
        if (int'(src_b) < NREG) begin
            val_b = regs_r[src_b];
        end else begin
            val_b = 64'd0;
        end
    end

    // Storage update; port M checked first so popq %rsp keeps the loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_m && (dst_m == 4'(i))) begin
                    regs_r[i] <= val_m;
                end else if (we_e && (dst_e == 4'(i))) begin
                    regs_r[i] <= val_e;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/y86_wb_regfile.sv
// Y86-64 SEQ write-back: register ID decode, register file, sticky status machine
// and retired-instruction counter. Once status leaves AOK nothing else is committed.
module y86_wb_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int CNTW = 32
) (
    input logic               clk,
    input logic               rst,
    y86_wb_regfile_if.slave   bus
);

    logic [3:0]      src_a_s, src_b_s, dst_e_s, dst_m_s;
    stat_e           stat_r, stat_next_s, instr_stat_s;
    logic            halted_r;
    logic            commit_ok_s;
    logic [CNTW-1:0] retired_r;

    // Register ID decode from the instruction fields.
    always_comb begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (bus.icode)
            IRRMOVQ: begin
                src_a_s = bus.rA;
                dst_e_s = bus.cnd ? bus.rB : RNONE;
            end
            IIRMOVQ: dst_e_s = bus.rB;
            IRMMOVQ: begin
                src_a_s = bus.rA;
                src_b_s = bus.rB;
            end
            IMRMOVQ: begin
                src_b_s = bus.rB;
                dst_m_s = bus.rA;
            end
            IOPQ: begin
                src_a_s = bus.rA;
                src_b_s = bus.rB;
                dst_e_s = bus.rB;
            end
            ICALL: begin
                src_b_s = RRSP;
                dst_e_s = RRSP;
            end
            IRET: begin
                src_a_s = RRSP;
                src_b_s = RRSP;
                dst_e_s = RRSP;
            end
            IPUSHQ: begin
                src_a_s = bus.rA;
                src_b_s = RRSP;
                dst_e_s = RRSP;
            end
            IPOPQ: begin
                src_a_s = RRSP;
                src_b_s = RRSP;
                dst_e_s = RRSP;
                dst_m_s = bus.rA;
            end
            default: begin
                src_a_s = RNONE;
                src_b_s = RNONE;
                dst_e_s = RNONE;
                dst_m_s = RNONE;
            end
        endcase
    end

    // Status next-state: only a committing instruction can move AOK to a stop state.
    always_comb begin
        instr_stat_s = next_stat(bus.imem_error, bus.dmem_error, bus.instr_valid, bus.icode);
        stat_next_s  = stat_r;
        commit_ok_s  = 1'b0;
        if (bus.commit && (stat_r == SAOK)) begin
            stat_next_s = instr_stat_s;
            commit_ok_s = (instr_stat_s == SAOK);
        end else begin
            stat_next_s = stat_r;
            commit_ok_s = 1'b0;
        end
    end

    // Status state register with a registered halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_r   <= SAOK;
            halted_r <= 1'b0;
        end else begin
            stat_r   <= stat_next_s;
            halted_r <= (stat_next_s != SAOK);
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= '0;
        end else if (commit_ok_s) begin
            retired_r <= retired_r + CNTW'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    y86_regfile #(.NREG(NREG)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .src_a (src_a_s),
        .src_b (src_b_s),
        .val_a (bus.valA),
        .val_b (bus.valB),
        .we_e  (commit_ok_s),
        .dst_e (dst_e_s),
        .val_e (bus.valE),
        .we_m  (commit_ok_s),
        .dst_m (dst_m_s),
        .val_m (bus.valM)
    );

    assign bus.srcA    = src_a_s;
    assign bus.srcB    = src_b_s;
    assign bus.dstE    = dst_e_s;
    assign bus.dstM    = dst_m_s;
    assign bus.stat    = stat_r;
    assign bus.halted  = halted_r;
    assign bus.retired = retired_r;

endmodule

// File: doc/y86_wb_regfile.md
# y86_wb_regfile

Write-back stage and architectural register file for the Y86-64 SEQ datapath. It sits directly downstream of the memory stage and consumes its `valM` together with the execute result `valE`. It serves the decode-side read ports (`valA`/`valB`) in the same cycle and commits register writes and the processor status on the clock edge. A sticky status machine stops all architectural updates once the processor leaves AOK.

## Interface
- `NREG`, 15 — architectural registers `%rax`..`%r14`; index 15 (`RNONE`) is never stored.
- `CNTW`, 32 — width of the retired-instruction counter.

- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-high reset.
- `commit` in 1 — the current instruction completes this cycle.
- `icode` in 4 — instruction code (0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq).
- `cnd` in 1 — condition result from execute; gates cmovXX.
- `rA`, `rB` in 4 — register specifiers from fetch.
- `valE`, `valM` in 64 — signed execute result and memory read data.
- `imem_error`, `dmem_error`, `instr_valid` in 1 — fault flags for the current instruction.
- `srcA`, `srcB`, `dstE`, `dstM` out 4 — decoded register IDs; 15 means none.
- `valA`, `valB` out 64 — register file read data for `srcA`/`srcB`.
- `stat` out 3 — 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `halted` out 1 — high whenever `stat` ≠ AOK.
- `retired` out `CNTW` — count of committed AOK instructions.

## Operation
- **srcA**
  - `rA` for icode 2, 4, 6, A.
  - 4 (`%rsp`) for icode 9, B.
  - Else 15.
- **srcB**
  - `rB` for icode 4, 5, 6.
  - 4 for icode 8, 9, A, B.
  - Else 15.
- **dstE**
  - `rB` for icode 3 and 6.
  - `rB` for icode 2 when `cnd`=1; 15 when `cnd`=0.
  - 4 for icode 8, 9, A, B.
  - Else 15.
- **dstM**
  - `rA` for icode 5 and B.
  - Else 15.
- Reads are combinational.
  - ID 15 returns 0.
  - No write bypass: a read in the same cycle as a write returns the pre-write value.
- Next status, priority high to low:
  - `imem_error` or `dmem_error` → ADR.
  - `!instr_valid` → INS.
  - icode 0 → HLT.
  - Otherwise AOK.
- Commit qualifies only when `commit`=1, current `stat`=AOK and next status = AOK.
  - On a qualified commit, write `valE`→R[`dstE`] and `valM`→R[`dstM`], skipping ID 15.
  - On a qualified commit, increment `retired`.
  - If `dstE`=`dstM`, `valM` wins (e.g. popq `%rsp`).
- Status FSM:
  - AOK → {HLT, ADR, INS} on `commit` with a non-AOK next status. The faulting or halting instruction writes nothing and is not counted.
  - HLT, ADR and INS are absorbing until `rst`.
  - With `commit`=0, the state holds.
- `retired` wraps modulo 2^`CNTW`.

## Timing
- Reset (asynchronous, effective immediately, also mid-operation):
  - All registers 0, `stat`=AOK, `halted`=0, `retired`=0.
  - `srcA`/`srcB`/`dstE`/`dstM`/`valA`/`valB` follow their combinational inputs from the reset values.
- Write latency 1 cycle: the value written at edge *n* is visible on `valA`/`valB` after edge *n*.
- `stat` and `halted` update on the same edge as the faulting commit.
- Release of `rst` is synchronous to `clk` externally; the block needs no reset synchroniser.

## Structure
- Shared package `y86_pkg`:
  - icode constants (`IHALT`..`IPOPQ`).
  - `RRSP`=4, `RNONE`=15.
  - stat constants `SAOK`/`SHLT`/`SADR`/`SINS`.
- Sub-module `y86_regfile`: 15×64 storage, 2 combinational read ports, 2 write ports with port-M priority, asynchronous reset clear.
- Top level holds the ID decode, the status FSM and the counter.

## Test plan
- Reset, then irmovq (icode 3, rB=2, valE=10), commit → R2=10, `retired`=1; next cycle `srcA`=2 via rrmovq shows `valA`=10.
- cmovXX (icode 2, rA=2, rB=3, valE=10) with `cnd`=0 → `dstE`=15, R3 unchanged; repeat with `cnd`=1 → R3=10.
- popq `%rsp` (icode B, rA=4, valE=0x108, valM=0x55) → R4=0x55, not 0x108.
- mrmovq with `dstM`=5 and `dstE`=15, `dstM` committed with `dmem_error`=1 → `stat`=ADR, R5 unchanged, `retired` unchanged; later commits with valid data are ignored.
- halt (icode 0) commit → `stat`=HLT, `halted`=1; assert `rst` mid-cycle → immediate AOK, all registers 0, `retired`=0.
- `instr_valid`=0 together with `imem_error`=1 → `stat`=ADR (ADR has priority over INS).
